// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell and a carry flip-flop process
// X + Y LSB first over WIDTH cycles, sequenced by a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sum_bit_s;
  logic             carry_out_s;
  logic             last_bit_s;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign sum_bit_s   = a_q[0] ^ b_q[0] ^ carry_q;
  assign carry_out_s = majority3(a_q[0], b_q[0], carry_q);
  assign last_bit_s  = (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and handshake next values; S/C move only on the final bit
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = X;
          b_d     = Y;
          carry_d = 1'b0;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d   = cnt_q;
        end
      end
      ST_RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        r_d     = {sum_bit_s, r_q[WIDTH-1:1]};
        carry_d = carry_out_s;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit_s) begin
          s_d = {sum_bit_s, r_q[WIDTH-1:1]};
          c_d = carry_out_s;
        end else begin
          s_d = s_q;
        end
      end
      ST_DONE: cnt_d = cnt_q;
      default: cnt_d = {CW{1'b0}};
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      s_q     <= {WIDTH{1'b0}};
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign C    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus randomized traffic,
// compared every cycle against a timeline/arithmetic reference model.
module tb_serial_adder;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;

  int n_checks;
  int n_fail;

  // reference model: operation timeline counted in edges since acceptance
  bit             m_active;
  int             m_cyc;
  bit             m_busy;
  bit             m_done;
  logic [WIDTH:0] m_pend;
  logic [WIDTH-1:0] m_s;
  logic           m_c;
  int             done_seen;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .X     (X),
    .Y     (Y),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_cyc    = 0;
    m_busy   = 1'b0;
    m_done   = 1'b0;
    m_s      = '0;
    m_c      = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start) begin
        m_active = 1'b1;
        m_cyc    = 0;
        m_pend   = {1'b0, X} + {1'b0, Y};
        m_busy   = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      m_cyc++;
      if (m_cyc == WIDTH) begin
        m_done = 1'b1;
        m_s    = m_pend[WIDTH-1:0];
        m_c    = m_pend[WIDTH];
      end else if (m_cyc == WIDTH + 1) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("done", 32'(done), 32'(m_done));
    check_eq("S", 32'(S), 32'(m_s));
    check_eq("C", 32'(C), 32'(m_c));
    if (done) done_seen++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_active && guard < 3 * WIDTH + 8) begin
      step();
      guard++;
    end
    check_eq("idle_timeout", 32'(m_active), 32'd0);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] yb);
    X = xa;
    Y = yb;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
  endtask

  logic [WIDTH-1:0] dx [4] = '{4'd10, 4'd13, 4'd15, 4'd0};
  logic [WIDTH-1:0] dy [4] = '{4'd5,  4'd8,  4'd15, 4'd0};
  logic [WIDTH-1:0] ds [4] = '{4'b1111, 4'b0101, 4'b1110, 4'b0000};
  logic             dc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step();

    // directed operations with fixed expected results
    for (int i = 0; i < 4; i++) begin
      done_seen = 0;
      run_op(dx[i], dy[i]);
      check_eq("dir_S", 32'(S), 32'(ds[i]));
      check_eq("dir_C", 32'(C), 32'(dc[i]));
      check_eq("dir_done_cnt", 32'(done_seen), 32'd1);
      step();
    end

    // start pulsed during RUN must be ignored
    done_seen = 0;
    X = 4'd2; Y = 4'd10; start = 1'b1;
    step();
    start = 1'b0;
    step();
    X = 4'd15; Y = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    wait_idle();
    repeat (3) step();
    check_eq("ign_S", 32'(S), 32'(4'b1100));
    check_eq("ign_C", 32'(C), 32'd0);
    check_eq("ign_done_cnt", 32'(done_seen), 32'd1);

    // start held high: back-to-back ops every WIDTH+2 cycles
    done_seen = 0;
    X = 4'd6; Y = 4'd10; start = 1'b1;
    for (int c = 0; c < 3 * (WIDTH + 2); c++) begin
      step();
    end
    check_eq("held_done_cnt", 32'(done_seen), 32'd3);
    check_eq("held_S", 32'(S), 32'd0);
    check_eq("held_C", 32'(C), 32'd1);
    step();
    X = 4'd3; Y = 4'd3;
    start = 1'b0;
    wait_idle();
    check_eq("inflight_S", 32'(S), 32'd0);
    check_eq("inflight_C", 32'(C), 32'd1);
    step();

    // asynchronous reset two bits into an operation
    X = 4'd9; Y = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_S", 32'(S), 32'd0);
    check_eq("arst_C", 32'(C), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_op(4'd8, 4'd6);
    check_eq("post_rst_S", 32'(S), 32'(4'b1110));
    check_eq("post_rst_C", 32'(C), 32'd0);

    // randomized traffic with occasional stray start pulses
    for (int i = 0; i < 40; i++) begin
      start = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      X = WIDTH'($urandom);
      Y = WIDTH'($urandom);
      start = 1'b1;
      step();
      for (int c = 0; c < WIDTH + 1; c++) begin
        start = ($urandom_range(0, 3) == 0);
        X = WIDTH'($urandom);
        Y = WIDTH'($urandom);
        step();
      end
      start = 1'b0;
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
